// File: rtl/csr_stage_if.sv
// Execute-to-CSR bundle: timer counters, incoming instruction fields and the
// registered results handed to writeback.
interface csr_stage_if;
  logic [63:0] reg_cycle;
  logic [63:0] reg_time;
  logic [63:0] reg_mtime;
  logic [63:0] reg_mtimecmp;
  logic        wb_branch_hazard;
  logic [63:0] input_inst_id;
  logic [2:0]  input_csr_cmd;
  logic [31:0] input_op1_data;
  logic [31:0] input_imm_i;
  logic        input_interrupt_ready;
  logic [31:0] if_reg_pc;
  logic [2:0]  output_csr_cmd;
  logic [31:0] csr_rdata;
  logic [31:0] trap_vector;
  logic        output_stall_flg_may_interrupt;

  modport master (
    output reg_cycle, reg_time, reg_mtime, reg_mtimecmp, wb_branch_hazard, input_inst_id,
           input_csr_cmd, input_op1_data, input_imm_i, input_interrupt_ready, if_reg_pc,
    input  output_csr_cmd, csr_rdata, trap_vector, output_stall_flg_may_interrupt
  );

  modport slave (
    input  reg_cycle, reg_time, reg_mtime, reg_mtimecmp, wb_branch_hazard, input_inst_id,
           input_csr_cmd, input_op1_data, input_imm_i, input_interrupt_ready, if_reg_pc,
    output output_csr_cmd, csr_rdata, trap_vector, output_stall_flg_may_interrupt
  );
endinterface

// File: rtl/csr_stage.sv
// Machine-mode CSR unit: CSR read-modify-write, ECALL/MRET and machine timer
// interrupt entry, with results registered toward writeback.
module csr_stage #(
  parameter int unsigned FMAX_MHz = 27
) (
  input logic        clk,
  input logic        reset,
  csr_stage_if.slave bus
);

  localparam logic [2:0] CmdX     = 3'd0;
  localparam logic [2:0] CmdW     = 3'd1;
  localparam logic [2:0] CmdS     = 3'd2;
  localparam logic [2:0] CmdC     = 3'd3;
  localparam logic [2:0] CmdEcall = 3'd4;
  localparam logic [2:0] CmdMret  = 3'd5;
  localparam logic [2:0] CmdInt   = 3'd6;

  logic        mie_q, mie_d, mpie_q, mpie_d, mtie_q, mtie_d;
  logic [29:0] mtvec_q, mtvec_d, mepc_q, mepc_d;
  logic [31:0] mscratch_q, mscratch_d, mcause_q, mcause_d;
  logic [63:0] last_id_q, last_id_d;
  logic [2:0]  cmd_q, cmd_d;
  logic [31:0] rdata_q, rdata_d, tvec_q, tvec_d;

  logic [11:0] addr;
  logic        mtip, pending, new_inst, take_int, cmd_valid;
  logic [31:0] rd_val, wdata;
  logic        unused_bits;

  assign addr        = bus.input_imm_i[11:0];
  assign unused_bits = ^{bus.input_imm_i[31:12], bus.if_reg_pc[1:0]};
  assign mtip        = bus.reg_mtime >= bus.reg_mtimecmp;
  assign pending     = mie_q & mtie_q & mtip;
  assign cmd_valid   = (bus.input_csr_cmd >= CmdW) && (bus.input_csr_cmd <= CmdMret);
  // A repeated id means upstream is stalled on an instruction already executed.
  assign new_inst    = !bus.wb_branch_hazard && cmd_valid && (bus.input_inst_id != last_id_q);
  assign take_int    = pending && bus.input_interrupt_ready && !bus.wb_branch_hazard && !new_inst;

  always_comb begin
    rd_val = 32'h0;
    case (addr)
      12'h300: rd_val = {24'h0, mpie_q, 3'b000, mie_q, 3'b000};
      12'h304: rd_val = {24'h0, mtie_q, 7'h0};
      12'h305: rd_val = {mtvec_q, 2'b00};
      12'h340: rd_val = mscratch_q;
      12'h341: rd_val = {mepc_q, 2'b00};
      12'h342: rd_val = mcause_q;
      12'h344: rd_val = {24'h0, mtip, 7'h0};
      12'hC00: rd_val = bus.reg_cycle[31:0];
      12'hC80: rd_val = bus.reg_cycle[63:32];
      12'hC01: rd_val = bus.reg_time[31:0];
      12'hC81: rd_val = bus.reg_time[63:32];
      default: rd_val = 32'h0;
    endcase
  end

  always_comb begin
    wdata = bus.input_op1_data;
    case (bus.input_csr_cmd)
      CmdS:    wdata = rd_val | bus.input_op1_data;
      CmdC:    wdata = rd_val & ~bus.input_op1_data;
      default: wdata = bus.input_op1_data;
    endcase
  end

  always_comb begin
    mie_d      = mie_q;
    mpie_d     = mpie_q;
    mtie_d     = mtie_q;
    mtvec_d    = mtvec_q;
    mepc_d     = mepc_q;
    mscratch_d = mscratch_q;
    mcause_d   = mcause_q;
    last_id_d  = last_id_q;
    cmd_d      = CmdX;
    rdata_d    = rdata_q;
    tvec_d     = tvec_q;
    if (new_inst) begin
      cmd_d     = bus.input_csr_cmd;
      rdata_d   = rd_val;
      last_id_d = bus.input_inst_id;
      case (bus.input_csr_cmd)
        CmdW, CmdS, CmdC: begin
          case (addr)
            12'h300: begin
              mie_d  = wdata[3];
              mpie_d = wdata[7];
            end
            12'h304: mtie_d     = wdata[7];
            12'h305: mtvec_d    = wdata[31:2];
            12'h340: mscratch_d = wdata;
            12'h341: mepc_d     = wdata[31:2];
            12'h342: mcause_d   = wdata;
            default: ;
          endcase
        end
        CmdEcall: begin
          mepc_d   = bus.input_op1_data[31:2];
          mcause_d = 32'd11;
          mpie_d   = mie_q;
          mie_d    = 1'b0;
          tvec_d   = {mtvec_q, 2'b00};
        end
        CmdMret: begin
          mie_d  = mpie_q;
          mpie_d = 1'b1;
          tvec_d = {mepc_q, 2'b00};
        end
        default: ;
      endcase
    end else if (take_int) begin
      cmd_d    = CmdInt;
      mepc_d   = bus.if_reg_pc[31:2];
      mcause_d = 32'h8000_0007;
      mpie_d   = mie_q;
      mie_d    = 1'b0;
      tvec_d   = {mtvec_q, 2'b00};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mie_q      <= 1'b0;
      mpie_q     <= 1'b0;
      mtie_q     <= 1'b0;
      mtvec_q    <= '0;
      mepc_q     <= '0;
      mscratch_q <= '0;
      mcause_q   <= '0;
      last_id_q  <= '1;
      cmd_q      <= CmdX;
      rdata_q    <= '0;
      tvec_q     <= '0;
    end else begin
      mie_q      <= mie_d;
      mpie_q     <= mpie_d;
      mtie_q     <= mtie_d;
      mtvec_q    <= mtvec_d;
      mepc_q     <= mepc_d;
      mscratch_q <= mscratch_d;
      mcause_q   <= mcause_d;
      last_id_q  <= last_id_d;
      cmd_q      <= cmd_d;
      rdata_q    <= rdata_d;
      tvec_q     <= tvec_d;
    end
  end

  assign bus.output_csr_cmd                 = cmd_q;
  assign bus.csr_rdata                      = rdata_q;
  assign bus.trap_vector                    = tvec_q;
  assign bus.output_stall_flg_may_interrupt = pending;

endmodule

// File: tb/tb_csr_stage.sv
// Directed and random checks of csr_stage against a CSR-map model that keeps
// each CSR as a masked 32-bit word.
module tb_csr_stage;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  csr_stage_if bus ();
  csr_stage #(.FMAX_MHz(27)) dut (.clk(clk), .reset(reset), .bus(bus));

  int total = 0;
  int bad = 0;
  logic [31:0] m_csr [int];
  logic [63:0] m_last, next_id, prev_id;
  logic [31:0] exp_cmd, exp_rdata, exp_tvec;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] wmask(input int a);
    case (a)
      'h300:        return 32'h0000_0088;
      'h304:        return 32'h0000_0080;
      'h305, 'h341: return 32'hFFFF_FFFC;
      default:      return 32'hFFFF_FFFF;
    endcase
  endfunction

  function automatic logic [31:0] mread(input int a);
    case (a)
      'h344:   return (bus.reg_mtime >= bus.reg_mtimecmp) ? 32'h80 : 32'h0;
      'hC00:   return bus.reg_cycle[31:0];
      'hC80:   return bus.reg_cycle[63:32];
      'hC01:   return bus.reg_time[31:0];
      'hC81:   return bus.reg_time[63:32];
      default: return m_csr.exists(a) ? m_csr[a] : 32'h0;
    endcase
  endfunction

  task automatic model_reset();
    m_csr['h300] = 0; m_csr['h304] = 0; m_csr['h305] = 0;
    m_csr['h340] = 0; m_csr['h341] = 0; m_csr['h342] = 0;
    m_last = '1;
    exp_cmd = 0; exp_rdata = 0; exp_tvec = 0;
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b1;
    @(posedge clk); #1;
    model_reset();
    reset = 1'b0;
    chk({tag, ".cmd"}, {29'h0, bus.output_csr_cmd}, 32'h0);
    chk({tag, ".rdata"}, bus.csr_rdata, 32'h0);
    chk({tag, ".tvec"}, bus.trap_vector, 32'h0);
    chk({tag, ".stall"}, {31'h0, bus.output_stall_flg_may_interrupt}, 32'h0);
  endtask

  // Drive one cycle, predict from the model, then check registered outputs.
  task automatic step(input logic [2:0] cmd, input int addr, input logic [31:0] op1,
                      input logic [63:0] id, input bit hz, input bit rdy,
                      input logic [31:0] pc, input string tag);
    logic [31:0] mst, old, nv;
    bit pend, newi;
    bus.input_csr_cmd = cmd;
    bus.input_imm_i = addr;
    bus.input_op1_data = op1;
    bus.input_inst_id = id;
    bus.wb_branch_hazard = hz;
    bus.input_interrupt_ready = rdy;
    bus.if_reg_pc = pc;
    #1;
    mst = m_csr['h300];
    pend = mst[3] && m_csr['h304][7] && (bus.reg_mtime >= bus.reg_mtimecmp);
    chk({tag, ".stall"}, {31'h0, bus.output_stall_flg_may_interrupt}, {31'h0, pend});
    newi = !hz && cmd >= 1 && cmd <= 5 && id != m_last;
    exp_cmd = 0;
    if (newi) begin
      exp_cmd = cmd;
      m_last = id;
      old = mread(addr);
      exp_rdata = old;
      if (cmd <= 3) begin
        nv = (cmd == 1) ? op1 : (cmd == 2) ? (old | op1) : (old & ~op1);
        if (m_csr.exists(addr)) m_csr[addr] = nv & wmask(addr);
      end else if (cmd == 4) begin
        m_csr['h341] = op1 & 32'hFFFF_FFFC;
        m_csr['h342] = 11;
        m_csr['h300] = mst[3] ? 32'h80 : 32'h0;
        exp_tvec = m_csr['h305];
      end else begin
        m_csr['h300] = mst[7] ? 32'h88 : 32'h80;
        exp_tvec = m_csr['h341];
      end
    end else if (pend && rdy && !hz) begin
      exp_cmd = 6;
      m_csr['h341] = pc & 32'hFFFF_FFFC;
      m_csr['h342] = 32'h8000_0007;
      m_csr['h300] = 32'h80;
      exp_tvec = m_csr['h305];
    end
    @(posedge clk); #1;
    chk({tag, ".cmd"}, {29'h0, bus.output_csr_cmd}, exp_cmd);
    chk({tag, ".rdata"}, bus.csr_rdata, exp_rdata);
    chk({tag, ".tvec"}, bus.trap_vector, exp_tvec);
  endtask

  task automatic csr(input logic [2:0] cmd, input int addr, input logic [31:0] op1,
                     input string tag);
    next_id++;
    step(cmd, addr, op1, next_id, 1'b0, 1'b0, 32'h0, tag);
  endtask

  // Non-destructive read; also checks against a hand-derived constant.
  task automatic rd(input int addr, input logic [31:0] want, input string tag);
    csr(3'd2, addr, 32'h0, tag);
    chk({tag, ".const"}, bus.csr_rdata, want);
  endtask

  initial begin
    int addrs [14] = '{'h300, 'h304, 'h305, 'h340, 'h341, 'h342, 'h344, 'hC00, 'hC80,
                       'hC01, 'hC81, 'hF14, 'h7C0, 'h123};
    next_id = 0;
    bus.reg_cycle = 64'h0000_0007_0000_0003;
    bus.reg_time = 0;
    bus.reg_mtime = 0;
    bus.reg_mtimecmp = 100;
    bus.input_csr_cmd = 0; bus.input_imm_i = 0; bus.input_op1_data = 0;
    bus.input_inst_id = 0; bus.wb_branch_hazard = 0; bus.input_interrupt_ready = 0;
    bus.if_reg_pc = 0;
    model_reset();
    do_reset("reset");

    csr(3'd1, 'h305, 32'h8000_0100, "mtvec_w");
    chk("mtvec_w.old", bus.csr_rdata, 32'h0);
    chk("mtvec_w.cmd1", {29'h0, bus.output_csr_cmd}, 32'h1);
    rd('h305, 32'h8000_0100, "mtvec_rd");

    csr(3'd1, 'h340, 32'hF0, "mscr_w");
    csr(3'd2, 'h340, 32'h0F, "mscr_s");
    chk("mscr_s.old", bus.csr_rdata, 32'hF0);
    for (int i = 0; i < 3; i++) step(3'd2, 'h340, 32'h0F, next_id, 0, 0, 0, "mscr_hold");
    chk("mscr_hold.rdata", bus.csr_rdata, 32'hF0);
    rd('h340, 32'hFF, "mscr_rd");

    csr(3'd1, 'h305, 32'h200, "mtvec_200");
    csr(3'd2, 'h300, 32'h8, "mie_set");
    csr(3'd4, 0, 32'h1000, "ecall");
    chk("ecall.tv", bus.trap_vector, 32'h200);
    rd('h341, 32'h1000, "ecall_mepc");
    rd('h342, 32'd11, "ecall_mcause");
    rd('h300, 32'h80, "ecall_mstatus");
    csr(3'd5, 0, 32'h0, "mret");
    chk("mret.tv", bus.trap_vector, 32'h1000);
    rd('h300, 32'h88, "mret_mstatus");

    csr(3'd2, 'h304, 32'h80, "mtie_set");
    bus.reg_mtime = 10;
    bus.reg_mtimecmp = 5;
    step(3'd0, 0, 0, next_id + 1, 0, 0, 32'h2004, "int_wait");
    chk("int_wait.stall", {31'h0, bus.output_stall_flg_may_interrupt}, 32'h1);
    step(3'd0, 0, 0, next_id + 1, 0, 1, 32'h2004, "int_take");
    chk("int_take.cmd6", {29'h0, bus.output_csr_cmd}, 32'h6);
    chk("int_take.stall", {31'h0, bus.output_stall_flg_may_interrupt}, 32'h0);
    rd('h341, 32'h2004, "int_mepc");
    rd('h342, 32'h8000_0007, "int_mcause");

    next_id++;
    step(3'd1, 'h340, 32'h1234, next_id, 1, 0, 0, "hazard");
    rd('h340, 32'hFF, "hazard_mscr");

    bus.reg_time = 64'h1_0000_0005;
    rd('hC01, 32'h5, "time_lo");
    rd('hC81, 32'h1, "time_hi");
    rd('h7C0, 32'h0, "unmapped");

    prev_id = next_id;
    for (int i = 0; i < 300; i++) begin
      logic [63:0] id;
      bus.reg_mtime = $urandom_range(0, 15);
      bus.reg_mtimecmp = $urandom_range(0, 15);
      bus.reg_time = {$urandom, $urandom};
      bus.reg_cycle = {$urandom, $urandom};
      if ($urandom_range(0, 3) == 0) id = prev_id;
      else begin next_id++; id = next_id; end
      prev_id = id;
      step(3'($urandom_range(0, 5)), addrs[$urandom_range(0, 13)], $urandom, id,
           $urandom_range(0, 9) == 0, $urandom_range(0, 1) == 1, $urandom, "rand");
    end

    csr(3'd1, 'h300, 32'h8, "pre_rst_mie");
    csr(3'd1, 'h304, 32'h80, "pre_rst_mtie");
    bus.reg_mtime = 9;
    bus.reg_mtimecmp = 3;
    #1;
    chk("pre_rst.stall", {31'h0, bus.output_stall_flg_may_interrupt}, 32'h1);
    do_reset("mid_reset");
    rd('h300, 32'h0, "post_rst_mstatus");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
